// File: rtl/ssp_bus_master_pkg.sv
// +----------------------------------------------------------------------+
// | ssp_bus_master_pkg: shared defaults and FSM encodings for the master |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ssp_bus_master_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int RX_DEPTH_DEF = 4;
  localparam int CNT_W_DEF    = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_REQ = 2'd1;
  localparam logic [1:0] ST_RD_CAP = 2'd2;

  // Width of the burst read counter; kept at least one bit for RX_DEPTH==1.
  function automatic int rd_cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssp_bus_master_rx_hold.sv
// +----------------------------------------------------------------------+
// | ssp_rx_hold: one-entry rx_valid/rx_data output register              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ssp_rx_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              clear_b_i,
  input  logic              load_i,
  input  logic              take_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load in the same cycle as a take wins, so back-to-back bytes never gap.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (take_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_b_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/ssp_bus_master.sv
// +----------------------------------------------------------------------+
// | ssp_bus_master: SSP bus initiator, tx pass-through and rx burst drain|
// | Optional macro SSP_MASTER_STATS_EN adds tx_count/rx_count counters.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ssp_bus_master
  import ssp_bus_master_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RX_DEPTH = RX_DEPTH_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              pclk,
  input  logic              clear_b,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              psel,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              ssptxintr,
  input  logic              ssprxintr,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count
);

  localparam int             RCW     = rd_cnt_width(RX_DEPTH);
  localparam logic [RCW-1:0] RD_LAST = RCW'(RX_DEPTH - 1);

  state_t         state_q, state_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic           cap;

  // Every bus output is gated by clear_b, so a reset cycle can never strobe.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    tx_ready = 1'b0;
    psel     = 1'b0;
    pwrite   = 1'b0;
    pwdata   = '0;
    cap      = 1'b0;
    if (clear_b) begin
      case (state_q)
        ST_IDLE: begin
          tx_ready = !ssptxintr && !ssprxintr;
          if (ssprxintr) begin
            state_d  = ST_RD_REQ;
            rd_cnt_d = '0;
          end else if (tx_valid && !ssptxintr) begin
            psel   = 1'b1;
            pwrite = 1'b1;
            pwdata = tx_data;
          end
        end
        ST_RD_REQ: begin
          if (!rx_valid || rx_ready) begin
            psel    = 1'b1;
            state_d = ST_RD_CAP;
          end
        end
        ST_RD_CAP: begin
          cap      = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          state_d  = (rd_cnt_q == RD_LAST) ? ST_IDLE : ST_RD_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!clear_b) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  ssp_rx_hold #(
    .DATA_W (DATA_W)
  ) u_rx_hold (
    .clk_i       (pclk),
    .clear_b_i   (clear_b),
    .load_i      (cap),
    .take_i      (rx_valid && rx_ready),
    .load_data_i (prdata),
    .valid_o     (rx_valid),
    .data_o      (rx_data)
  );

`ifdef SSP_MASTER_STATS_EN
  logic [CNT_W-1:0] tx_count_q, rx_count_q;

  always_ff @(posedge pclk) begin
    if (!clear_b) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      if (psel && pwrite) tx_count_q <= tx_count_q + 1'b1;
      if (cap)            rx_count_q <= rx_count_q + 1'b1;
    end
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
`else
  assign tx_count = '0;
  assign rx_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ssp_bus_master.sv
// +----------------------------------------------------------------------+
// | tb_ssp_bus_master: directed and randomized checks of ssp_bus_master  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ssp_bus_master;

  localparam int DATA_W   = 8;
  localparam int RX_DEPTH = 4;
  localparam int CNT_W    = 16;
  localparam int N_RAND   = 1500;

  logic              pclk = 1'b0;
  logic              clear_b, tx_valid, rx_ready, ssptxintr, ssprxintr;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] prdata = '0;
  logic              tx_ready, rx_valid, psel, pwrite;
  logic [DATA_W-1:0] rx_data, pwdata;
  logic [CNT_W-1:0]  tx_count, rx_count;

  always #5 pclk = ~pclk;

  ssp_bus_master #(
    .DATA_W   (DATA_W),
    .RX_DEPTH (RX_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .pclk      (pclk),
    .clear_b   (clear_b),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .psel      (psel),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .ssptxintr (ssptxintr),
    .ssprxintr (ssprxintr),
    .tx_count  (tx_count),
    .rx_count  (rx_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] rd_src [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DATA_W-1:0] tx_seq [3] = '{8'hA1, 8'hB2, 8'hC3};
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] rnd_b;
  logic [DATA_W-1:0] prev_data;
  bit                prev_hold;
  bit                rand_mode = 1'b0;
  bit                strobe_seen = 1'b0;
  int                rd_idx = 0;
  int                n_wr_seen = 0;
  int                n_rd_seen = 0;
  int                n_deliv = 0;

  // SSP-side model: observe the bus mid-cycle, answer a read on the next edge.
  always @(negedge pclk) begin
    strobe_seen = psel && !pwrite;
    if (!clear_b) begin
      n_wr_seen = 0;
      n_rd_seen = 0;
    end else begin
      if (psel && pwrite)  n_wr_seen++;
      if (psel && !pwrite) n_rd_seen++;
    end
  end

  always @(posedge pclk) begin
    if (strobe_seen) begin
      if (rand_mode) begin
        rnd_b = DATA_W'($urandom);
        prdata <= rnd_b;
        exp_q.push_back(rnd_b);
      end else begin
        prdata <= rd_src[rd_idx % 4];
        rd_idx++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    // Reset with stimulus that would otherwise start both a write and a burst
    clear_b = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF; ssprxintr = 1'b1;
    ssptxintr = 1'b0; rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_psel", psel, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_pwdata", pwdata, 0);
    end
    clear_b = 1'b1; tx_valid = 1'b0; ssprxintr = 1'b0;
    #1;
    chk("idle_tx_ready", tx_ready, 1);
    chk("idle_psel", psel, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    tick();

    // Back-to-back transmit stream
    foreach (tx_seq[k]) begin
      tx_valid = 1'b1; tx_data = tx_seq[k];
      #1;
      chk("tx_psel", psel, 1);
      chk("tx_pwrite", pwrite, 1);
      chk("tx_pwdata", pwdata, tx_seq[k]);
      tick();
    end
    tx_valid = 1'b0;
    #1;
    chk("tx_done_psel", psel, 0);
    tick();

    // Tx FIFO full blocks writes until it clears
    tx_valid = 1'b1; tx_data = 8'h55;
    #1;
    chk("full_pre_wr", psel && pwrite, 1);
    chk("full_pre_data", pwdata, 8'h55);
    tick();
    ssptxintr = 1'b1; tx_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_tx_ready", tx_ready, 0);
      chk("full_psel", psel, 0);
      tick();
    end
    ssptxintr = 1'b0;
    #1;
    chk("full_resume_wr", psel && pwrite, 1);
    chk("full_resume_data", pwdata, 8'h66);
    tick();
    tx_valid = 1'b0;

    // Receive drain with the sink always ready
    ssprxintr = 1'b1;
    #1;
    chk("drain_start_psel", psel, 0);
    chk("drain_start_txrdy", tx_ready, 0);
    tick();
    ssprxintr = 1'b0;
    for (int k = 0; k < RX_DEPTH; k++) begin
      #1;
      chk("drain_rd_strobe", psel && !pwrite, 1);
      chk("drain_req_txrdy", tx_ready, 0);
      tick();
      #1;
      chk("drain_cap_psel", psel, 0);
      tick();
      chk("drain_rx_valid", rx_valid, 1);
      chk("drain_rx_data", rx_data, rd_src[k]);
    end
    #1;
    chk("drain_back_idle", tx_ready, 1);
    chk("drain_idle_psel", psel, 0);
    tick();
    chk("drain_rx_cleared", rx_valid, 0);

    // Receive backpressure holds the first byte and stalls the next strobe
    rx_ready = 1'b0; ssprxintr = 1'b1;
    #1;
    tick();
    ssprxintr = 1'b0;
    #1;
    chk("bp_first_strobe", psel && !pwrite, 1);
    tick();
    tick();
    chk("bp_first_valid", rx_valid, 1);
    chk("bp_first_data", rx_data, 8'h11);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_no_strobe", psel, 0);
      chk("bp_hold_valid", rx_valid, 1);
      chk("bp_hold_data", rx_data, 8'h11);
      tick();
    end
    rx_ready = 1'b1;
    for (int k = 1; k < RX_DEPTH; k++) begin
      #1;
      chk("bp_resume_strobe", psel && !pwrite, 1);
      tick();
      tick();
      chk("bp_resume_data", rx_data, rd_src[k]);
    end
    #1;
    chk("bp_back_idle", tx_ready, 1);
    tick();

    // Read wins a tie with a write; then reset abandons the burst
    tx_valid = 1'b1; tx_data = 8'h77; ssprxintr = 1'b1;
    #1;
    chk("tie_no_write", psel, 0);
    chk("tie_tx_ready", tx_ready, 0);
    tick();
    tx_valid = 1'b0; ssprxintr = 1'b0;
    #1;
    chk("tie_rd_strobe", psel && !pwrite, 1);
    tick();
    tick();
    chk("tie_rx_valid", rx_valid, 1);
    rx_ready = 1'b0; clear_b = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_tx_ready", tx_ready, 0);
    tick();
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_rx_data", rx_data, 0);
    clear_b = 1'b1;
    #1;
    chk("midrst_idle", tx_ready, 1);
    chk("midrst_no_strobe", psel, 0);
    chk("midrst_tx_count", tx_count, 0);
    chk("midrst_rx_count", rx_count, 0);
    tick();

    // Randomized traffic against transaction-level rules and a byte scoreboard
    rand_mode = 1'b1;
    prev_hold = 1'b0;
    prev_data = '0;
    for (int c = 0; c < N_RAND; c++) begin
      tx_valid  = ($urandom_range(9, 0) < 7);
      tx_data   = DATA_W'($urandom);
      ssptxintr = ($urandom_range(9, 0) < 2);
      if (c < N_RAND - 40) begin
        ssprxintr = ($urandom_range(9, 0) < 1);
        rx_ready  = ($urandom_range(9, 0) < 6);
      end else begin
        ssprxintr = 1'b0;
        rx_ready  = 1'b1;
      end
      #1;
      if (ssptxintr || ssprxintr) chk("rnd_txrdy_blocked", tx_ready, 0);
      chk("rnd_wr_iff_hs", psel && pwrite, tx_valid && tx_ready);
      if (psel && pwrite) begin
        chk("rnd_wr_data", pwdata, tx_data);
        chk("rnd_wr_not_midburst", n_rd_seen % RX_DEPTH, 0);
      end
      if (psel && !pwrite) begin
        chk("rnd_rd_no_overrun", rx_valid && !rx_ready, 0);
        chk("rnd_rd_txrdy", tx_ready, 0);
      end
      if (prev_hold) begin
        chk("rnd_hold_valid", rx_valid, 1);
        chk("rnd_hold_data", rx_data, prev_data);
      end
      if (rx_valid && rx_ready) begin
        chk("rnd_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("rnd_rx_data", rx_data, exp_q.pop_front());
          n_deliv++;
        end
      end
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
      tick();
    end
    tx_valid = 1'b0;
    #1;
    chk("rnd_q_drained", exp_q.size(), 0);
    chk("rnd_some_bytes", n_deliv > 0, 1);
    chk("rnd_whole_bursts", n_rd_seen % RX_DEPTH, 0);
`ifdef SSP_MASTER_STATS_EN
    chk("stat_tx_count", tx_count, CNT_W'(n_wr_seen));
    chk("stat_rx_count", rx_count, CNT_W'(n_rd_seen));
`else
    chk("stat_tx_count_tied", tx_count, 0);
    chk("stat_rx_count_tied", rx_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
